// File: rtl/prog_mem_pkg.sv
// Shared definitions for the jacaranda-8 program memory: loader command
// encodings and the load-session state machine states.
package prog_mem_pkg;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_ADDR  = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_END   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Single-write, single-read synchronous RAM with read-first collision
// behaviour and no reset, so it can map onto an SRAM macro or plain flops.
module prog_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Instruction memory with a registered CPU fetch port and a command-driven
// program loader (auto-incrementing pointer, running checksum, CPU hold).
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [1:0]        ld_cmd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ld_ptr,
    output logic [ADDR_W:0]   ld_count,
    output logic [DATA_W-1:0] ld_sum,
    output logic              ld_err
);

    localparam logic [ADDR_W:0]   COUNT_MAX = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    state_t            state;
    logic              accept;
    logic              wr_en;
    logic              primed;
    logic [DATA_W-1:0] ram_q;

    assign accept = ld_valid && ld_ready;
    assign wr_en  = accept && (state == ST_LOAD) && (ld_cmd == CMD_DATA);

    prog_mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (ld_ptr),
        .wr_data (ld_data),
        .rd_en   (fetch_en),
        .rd_addr (fetch_addr),
        .rd_data (ram_q)
    );

    // The RAM has no reset; until the first fetch after reset the port reads 0.
    assign fetch_data = primed ? ram_q : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            primed      <= 1'b0;
        end else begin
            fetch_valid <= fetch_en;
            primed      <= primed | fetch_en;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ld_ready <= 1'b0;
            cpu_hold <= 1'b0;
            ld_ptr   <= '0;
            ld_count <= '0;
            ld_sum   <= '0;
            ld_err   <= 1'b0;
        end else begin
            ld_ready <= 1'b1;
            if (state == ST_DRAIN) begin
                state    <= ST_IDLE;
                cpu_hold <= 1'b0;
            end else if (accept && ld_cmd == CMD_START) begin
                // START from IDLE opens a session; from LOAD it restarts one.
                state    <= ST_LOAD;
                cpu_hold <= 1'b1;
                ld_ptr   <= '0;
                ld_count <= '0;
                ld_sum   <= '0;
                ld_err   <= 1'b0;
            end else if (accept && state == ST_IDLE) begin
                ld_err <= 1'b1;
            end else if (accept && state == ST_LOAD) begin
                case (ld_cmd)
                    CMD_ADDR: ld_ptr <= ld_data[ADDR_W-1:0];
                    CMD_DATA: begin
                        ld_ptr <= ld_ptr + PTR_ONE;
                        ld_sum <= ld_sum + ld_data;
                        if (ld_count == COUNT_MAX) begin
                            ld_err <= 1'b1;
                        end else begin
                            ld_count <= ld_count + COUNT_ONE;
                        end
                    end
                    CMD_END: begin
                        state    <= ST_DRAIN;
                        ld_ready <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed table, corner sequences and a
// randomized run against a behavioural model of the load session and memory.
module tb_prog_mem;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_en = 1'b0;
    logic [7:0] fetch_addr = '0;
    logic [7:0] fetch_data;
    logic       fetch_valid;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [1:0] ld_cmd = '0;
    logic [7:0] ld_data = '0;
    logic       cpu_hold;
    logic [7:0] ld_ptr;
    logic [8:0] ld_count;
    logic [7:0] ld_sum;
    logic       ld_err;

    prog_mem #(.DATA_W(8), .ADDR_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_cmd      (ld_cmd),
        .ld_data     (ld_data),
        .cpu_hold    (cpu_hold),
        .ld_ptr      (ld_ptr),
        .ld_count    (ld_count),
        .ld_sum      (ld_sum),
        .ld_err      (ld_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: session flags, counters, memory image, fetch register.
    logic [7:0] mem_m [256];
    bit         m_hold, m_err, m_drain, m_ready, m_fvalid;
    int         m_ptr, m_count, m_sum;
    logic [7:0] m_fdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_err = 0; m_drain = 0; m_ready = 0; m_fvalid = 0;
        m_ptr = 0; m_count = 0; m_sum = 0; m_fdata = '0;
    endtask

    task automatic model_edge(input bit v, input int cmd, input int d,
                              input bit fen, input int fa);
        if (fen) m_fdata = mem_m[fa];
        m_fvalid = fen;
        if (m_drain) begin
            m_drain = 0;
            m_hold  = 0;
        end else if (v) begin
            if (cmd == 0) begin
                m_hold = 1; m_ptr = 0; m_count = 0; m_sum = 0; m_err = 0;
            end else if (!m_hold) begin
                m_err = 1;
            end else if (cmd == 1) begin
                m_ptr = d;
            end else if (cmd == 2) begin
                mem_m[m_ptr] = d[7:0];
                m_ptr = (m_ptr + 1) % 256;
                m_sum = (m_sum + d) % 256;
                if (m_count == 256) m_err = 1;
                else m_count++;
            end else begin
                m_drain = 1;
            end
        end
        m_ready = !m_drain;
    endtask

    task automatic check_all();
        chk("fetch_valid", 32'(fetch_valid), 32'(m_fvalid));
        if (!$isunknown(m_fdata)) chk("fetch_data", 32'(fetch_data), 32'(m_fdata));
        chk("ld_ready", 32'(ld_ready), 32'(m_ready));
        chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
        chk("ld_ptr", 32'(ld_ptr), 32'(m_ptr));
        chk("ld_count", 32'(ld_count), 32'(m_count));
        chk("ld_sum", 32'(ld_sum), 32'(m_sum));
        chk("ld_err", 32'(ld_err), 32'(m_err));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic cyc(input bit v, input int cmd, input int d, input bit fen, input int fa);
        ld_valid   = v;
        ld_cmd     = 2'(cmd);
        ld_data    = 8'(d);
        fetch_en   = fen;
        fetch_addr = 8'(fa);
        @(posedge clock);
        #1;
        model_edge(v, cmd, d, fen, fa);
        check_all();
    endtask

    typedef struct {
        bit         valid;
        int         cmd;
        int         data;
        bit         hold;
        int         ptr;
        int         cnt;
        int         sum;
        bit         err;
        bit         ready;
    } vec_t;

    vec_t       tbl[7];
    logic [7:0] saved[3];

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 'x;
        model_reset();

        tbl[0] = '{1, 0, 'h00, 1, 'h00, 0, 'h00, 0, 1};
        tbl[1] = '{1, 1, 'h10, 1, 'h10, 0, 'h00, 0, 1};
        tbl[2] = '{1, 2, 'hA5, 1, 'h11, 1, 'hA5, 0, 1};
        tbl[3] = '{1, 2, 'h3C, 1, 'h12, 2, 'hE1, 0, 1};
        tbl[4] = '{1, 3, 'h00, 1, 'h12, 2, 'hE1, 0, 0};
        tbl[5] = '{0, 0, 'h00, 0, 'h12, 2, 'hE1, 0, 1};
        tbl[6] = '{1, 2, 'h99, 0, 'h12, 2, 'hE1, 1, 1};

        // Reset state, including ld_ready low while reset is held.
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("ready_after_reset", 32'(ld_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].valid, tbl[i].cmd, tbl[i].data, 0, 0);
            chk($sformatf("tbl%0d_hold", i), 32'(cpu_hold), 32'(tbl[i].hold));
            chk($sformatf("tbl%0d_ptr", i), 32'(ld_ptr), 32'(tbl[i].ptr));
            chk($sformatf("tbl%0d_count", i), 32'(ld_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_sum", i), 32'(ld_sum), 32'(tbl[i].sum));
            chk($sformatf("tbl%0d_err", i), 32'(ld_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_ready", i), 32'(ld_ready), 32'(tbl[i].ready));
        end

        // Back-to-back fetches, then hold when fetch_en drops.
        cyc(0, 0, 0, 1, 'h10);
        chk("fetch10", 32'(fetch_data), 32'hA5);
        cyc(0, 0, 0, 1, 'h11);
        chk("fetch11", 32'(fetch_data), 32'h3C);
        chk("fetch11_valid", 32'(fetch_valid), 32'd1);
        cyc(0, 0, 0, 0, 'h10);
        chk("fetch_hold", 32'(fetch_data), 32'h3C);
        chk("fetch_idle_valid", 32'(fetch_valid), 32'd0);

        // Read-first collision.
        cyc(1, 0, 0, 0, 0);
        chk("start_clears_err", 32'(ld_err), 32'd0);
        cyc(1, 1, 'h20, 0, 0);
        cyc(1, 2, 'h11, 0, 0);
        cyc(1, 1, 'h20, 0, 0);
        cyc(1, 2, 'h77, 1, 'h20);
        chk("collision_old", 32'(fetch_data), 32'h11);
        cyc(0, 0, 0, 1, 'h20);
        chk("collision_new", 32'(fetch_data), 32'h77);

        // Pointer wrap.
        cyc(1, 1, 'hFF, 0, 0);
        cyc(1, 2, 'h01, 0, 0);
        cyc(1, 2, 'h02, 0, 0);
        chk("wrap_ptr", 32'(ld_ptr), 32'h01);
        cyc(1, 1, 'h10, 0, 0);
        cyc(1, 3, 0, 0, 0);
        chk("drain_hold", 32'(cpu_hold), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("idle_hold", 32'(cpu_hold), 32'd0);

        // DATA in IDLE: error, no write at ld_ptr (0x10).
        cyc(1, 2, 'h99, 0, 0);
        chk("idle_data_err", 32'(ld_err), 32'd1);
        cyc(0, 0, 0, 1, 'hFF);
        chk("wrap_memFF", 32'(fetch_data), 32'h01);
        cyc(0, 0, 0, 1, 'h00);
        chk("wrap_mem00", 32'(fetch_data), 32'h02);
        cyc(0, 0, 0, 1, 'h10);
        chk("idle_data_nowrite", 32'(fetch_data), 32'hA5);

        // 257 writes: saturation and overwrite error.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 257; i++) begin
            cyc(1, 2, int'($urandom_range(0, 255)), 0, 0);
            if (i == 255) begin
                chk("count_full", 32'(ld_count), 32'd256);
                chk("full_no_err", 32'(ld_err), 32'd0);
            end
        end
        chk("count_sat", 32'(ld_count), 32'd256);
        chk("overwrite_err", 32'(ld_err), 32'd1);
        cyc(1, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("restart_err_clear", 32'(ld_err), 32'd0);

        // Randomized mix of loader commands and fetches.
        for (int i = 0; i < 600; i++) begin
            int r;
            int cmd;
            r = int'($urandom_range(0, 15));
            cmd = (r == 0) ? 0 : (r == 1) ? 3 : (r < 5) ? 1 : 2;
            cyc($urandom_range(0, 3) != 0, cmd, int'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Reset mid-session after three writes.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 'h40, 0, 0);
        for (int i = 0; i < 3; i++) begin
            saved[i] = 8'($urandom_range(0, 255));
            cyc(1, 2, int'(saved[i]), 0, 0);
        end
        ld_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_hold_drop", 32'(cpu_hold), 32'd0);
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 'h40 + i);
            chk($sformatf("persist%0d", i), 32'(fetch_data), 32'(saved[i]));
        end
        cyc(1, 2, 'h55, 0, 0);
        chk("post_reset_idle", 32'(ld_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
